// File: rtl/data_writeback_cache_controller.sv
// Hit/miss sequencer for the 2-way write-back LRU data cache: store hits write in one cycle,
// misses evict (writing back a dirty victim) and refill the block from the bus while stalling the pipe.
module data_writeback_cache_controller #(
  parameter int tbits = 14,
  parameter int bsize = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRE,
  input  logic             MemWE,
  input  logic [tbits-1:0] PhysTag,
  input  logic             W1V,
  input  logic             W2V,
  input  logic             W1D,
  input  logic             W2D,
  input  logic [tbits-1:0] W1Tag,
  input  logic [tbits-1:0] W2Tag,
  input  logic             CurrLRU,
  input  logic             BusReady,
  output logic             W1WE,
  output logic             W2WE,
  output logic             DirtyIn,
  output logic             vin,
  output logic             UseBusWD,
  output logic             FullMask,
  output logic [1:0]       WordOffset,
  output logic             UseCount,
  output logic             WaySel,
  output logic             UseVictimTag,
  output logic             BusRE,
  output logic             BusWE,
  output logic             Stall
);
  localparam int cw = (bsize > 1) ? $clog2(bsize) : 1;

  typedef enum logic [1:0] {READY, WRITEBACK, FILL} state_t;

  state_t        state;
  logic [cw-1:0] count;
  logic          victim;

  logic hit1, hit2, hit, req, miss, vsel, last;

  assign hit1 = W1V && (W1Tag == PhysTag);
  assign hit2 = W2V && (W2Tag == PhysTag);
  assign hit  = hit1 | hit2;
  assign req  = MemRE | MemWE;
  assign miss = req & ~hit;
  // Fill an empty way first; otherwise evict the way that was not written most recently.
  assign vsel = !W1V ? 1'b0 : (!W2V ? 1'b1 : ~CurrLRU);
  assign last = (count == cw'(bsize - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= READY;
      count  <= '0;
      victim <= 1'b0;
    end else begin
      case (state)
        READY: begin
          if (miss) begin
            victim <= vsel;
            count  <= '0;
            state  <= (vsel ? W2D : W1D) ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (BusReady) begin
            count <= last ? '0 : count + 1'b1;
            if (last) state <= FILL;
          end
        end
        FILL: begin
          if (BusReady) begin
            count <= last ? '0 : count + 1'b1;
            if (last) state <= READY;
          end
        end
        default: state <= READY;
      endcase
    end
  end

  always_comb begin
    W1WE         = 1'b0;
    W2WE         = 1'b0;
    DirtyIn      = 1'b0;
    vin          = 1'b0;
    UseBusWD     = 1'b0;
    FullMask     = 1'b0;
    WordOffset   = 2'b00;
    UseCount     = 1'b0;
    WaySel       = 1'b0;
    UseVictimTag = 1'b0;
    BusRE        = 1'b0;
    BusWE        = 1'b0;
    Stall        = 1'b0;
    case (state)
      READY: begin
        if (req) begin
          WaySel = ~hit1 & hit2;
          Stall  = miss;
          if (MemWE && hit) begin
            W1WE    = hit1;
            W2WE    = ~hit1 & hit2;
            DirtyIn = 1'b1;
            vin     = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        Stall        = 1'b1;
        BusWE        = 1'b1;
        UseVictimTag = 1'b1;
        UseCount     = 1'b1;
        WordOffset   = 2'(count);
        WaySel       = victim;
      end
      FILL: begin
        Stall      = 1'b1;
        BusRE      = 1'b1;
        UseCount   = 1'b1;
        WordOffset = 2'(count);
        if (BusReady) begin
          W1WE     = ~victim;
          W2WE     = victim;
          UseBusWD = 1'b1;
          FullMask = 1'b1;
          vin      = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_data_writeback_cache_controller.sv
// Bench for data_writeback_cache_controller: transaction-level cache model feeds a per-cycle scoreboard.
module tb_data_writeback_cache_controller;
  localparam int TB = 14;
  localparam int BS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, MemRE, MemWE, W1V, W2V, W1D, W2D, CurrLRU, BusReady;
  logic [TB-1:0] PhysTag, W1Tag, W2Tag;
  logic          W1WE, W2WE, DirtyIn, vin, UseBusWD, FullMask, UseCount, WaySel;
  logic          UseVictimTag, BusRE, BusWE, Stall;
  logic [1:0]    WordOffset;

  data_writeback_cache_controller #(.tbits(TB), .bsize(BS)) dut (
    .clk(clk), .reset(reset), .MemRE(MemRE), .MemWE(MemWE), .PhysTag(PhysTag),
    .W1V(W1V), .W2V(W2V), .W1D(W1D), .W2D(W2D), .W1Tag(W1Tag), .W2Tag(W2Tag),
    .CurrLRU(CurrLRU), .BusReady(BusReady), .W1WE(W1WE), .W2WE(W2WE),
    .DirtyIn(DirtyIn), .vin(vin), .UseBusWD(UseBusWD), .FullMask(FullMask),
    .WordOffset(WordOffset), .UseCount(UseCount), .WaySel(WaySel),
    .UseVictimTag(UseVictimTag), .BusRE(BusRE), .BusWE(BusWE), .Stall(Stall)
  );

  typedef struct packed {
    logic       w1we, w2we, dirtyin, vin, usebuswd, fullmask;
    logic [1:0] wordoffset;
    logic       usecount, waysel, usevictimtag, busre, buswe, stall;
  } outs_t;

  typedef struct {
    bit       wb;
    bit [1:0] word;
  } beat_t;

  // Behavioural view of the indexed set plus the outstanding bus beats of a miss.
  bit            v[2], d[2], lru, victim_m;
  logic [TB-1:0] tg[2], miss_tag;
  beat_t         plan[$];
  outs_t         expq[$];
  int            total = 0, bad = 0;

  task automatic cycle(input bit re, input bit we, input logic [TB-1:0] pt,
                       input bit br, input bit rst);
    outs_t e;
    bit    h1, h2, hw, vict;
    beat_t b;
    MemRE = re; MemWE = we; PhysTag = pt; BusReady = br; reset = rst;
    W1V = v[0]; W2V = v[1]; W1D = d[0]; W2D = d[1];
    W1Tag = tg[0]; W2Tag = tg[1]; CurrLRU = lru;
    e = '0;
    if (plan.size() == 0) begin
      if (re || we) begin
        h1 = v[0] && tg[0] == pt;
        h2 = v[1] && tg[1] == pt;
        if (h1 || h2) begin
          hw = h1 ? 1'b0 : 1'b1;
          e.waysel = hw;
          if (we) begin
            if (hw) e.w2we = 1'b1; else e.w1we = 1'b1;
            e.dirtyin = 1'b1; e.vin = 1'b1;
            d[hw] = 1'b1; lru = hw;
          end
        end else begin
          e.stall = 1'b1;
          vict = !v[0] ? 1'b0 : (!v[1] ? 1'b1 : (lru ? 1'b0 : 1'b1));
          victim_m = vict; miss_tag = pt;
          if (d[vict]) for (int k = 0; k < BS; k++) plan.push_back('{1'b1, 2'(k)});
          for (int k = 0; k < BS; k++) plan.push_back('{1'b0, 2'(k)});
        end
      end
    end else begin
      b = plan[0];
      e.stall = 1'b1; e.usecount = 1'b1; e.wordoffset = b.word;
      if (b.wb) begin
        e.buswe = 1'b1; e.usevictimtag = 1'b1; e.waysel = victim_m;
      end else begin
        e.busre = 1'b1;
        if (br) begin
          if (victim_m) e.w2we = 1'b1; else e.w1we = 1'b1;
          e.usebuswd = 1'b1; e.fullmask = 1'b1; e.vin = 1'b1;
          v[victim_m] = 1'b1; tg[victim_m] = miss_tag; d[victim_m] = 1'b0; lru = victim_m;
        end
      end
      if (br) void'(plan.pop_front());
    end
    if (rst) plan.delete();
    expq.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    outs_t e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = '{W1WE, W2WE, DirtyIn, vin, UseBusWD, FullMask, WordOffset,
            UseCount, WaySel, UseVictimTag, BusRE, BusWE, Stall};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t got=%h exp=%h", $time, a, e);
      end
    end
  end

  logic [TB-1:0] pool[5] = '{14'h0A5, 14'h0B6, 14'h0C7, 14'h0D8, 14'h3FFF};

  initial begin
    bit            cre, cwe, rst;
    logic [TB-1:0] ctag;
    int            r;
    reset = 1'b1; MemRE = 0; MemWE = 0; PhysTag = '0; BusReady = 0;
    W1V = 0; W2V = 0; W1D = 0; W2D = 0; W1Tag = '0; W2Tag = '0; CurrLRU = 0;
    v = '{0, 0}; d = '{0, 0}; tg = '{14'h0, 14'h0}; lru = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle(0, 0, 14'h0, 0, 0);                              // reset state: all zero
    v[0] = 1; tg[0] = 14'h0A5;
    cycle(1, 0, 14'h0A5, 0, 0);                            // load hit way1
    v[1] = 1; tg[1] = 14'h0B6;
    cycle(0, 1, 14'h0B6, 0, 0);                            // store hit way2
    cycle(0, 0, 14'h0B6, 0, 0);
    v[0] = 0;
    repeat (6) cycle(1, 0, 14'h0C7, 1, 0);                 // clean miss into empty way1
    d[1] = 1; lru = 0;
    repeat (10) cycle(0, 1, 14'h0D8, 1, 0);                // dirty miss on way2, then store hit
    d = '{0, 0}; lru = 0;
    cycle(1, 0, 14'h0E9, 1, 0);
    foreach (pool[i]) if (i < 0) ;
    begin
      bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < 7; i++) cycle(1, 0, 14'h0E9, pat[i], 0);
    end
    cycle(1, 0, 14'h0E9, 1, 0);
    d = '{1, 1}; lru = 1;
    cycle(1, 0, 14'h0A5, 1, 0);                            // dirty miss, reset mid-writeback
    cycle(1, 0, 14'h0A5, 1, 0);
    cycle(1, 0, 14'h0A5, 1, 0);
    cycle(1, 0, 14'h0A5, 0, 1);
    cycle(0, 0, 14'h0A5, 0, 0);

    cre = 0; cwe = 0; ctag = pool[0];
    for (int n = 0; n < 3000; n++) begin
      if (plan.size() == 0) begin
        r = $urandom_range(0, 3);
        cre = (r == 1) || (r == 3);
        cwe = (r == 2);
        ctag = pool[$urandom_range(0, 4)];
      end else if ($urandom_range(0, 7) == 0) begin
        cre = 0; cwe = 0;
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle(cre, cwe, ctag, $urandom_range(0, 9) < 7, rst);
    end
    cycle(0, 0, 14'h0, 0, 1);
    @(negedge clk); #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_writeback_cache_controller.md
Name: data_writeback_cache_controller

Overview:
- Sequencing FSM for the 2-way, write-back, LRU data cache memory in the pipelined core's memory stage.
- On each CPU load or store it detects a hit or miss and drives the way write enables, dirty and valid inputs, and word offset.
- On a miss it picks a victim way, writes back the victim if dirty, then fills the block from the bus word by word, stalling the pipeline throughout.

Parameters:
tbits  14  tag width; must match the cache memory.
bsize  4   words per block; the word counter width is $clog2(bsize).

Ports:
clk           input   1      clock
reset         input   1      synchronous, active-high reset
MemRE         input   1      CPU load request this cycle
MemWE         input   1      CPU store request this cycle
PhysTag       input   tbits  tag of the current request
W1V, W2V      input   1      way valid bits for the indexed set
W1D, W2D      input   1      way dirty bits for the indexed set
W1Tag, W2Tag  input   tbits  way tags for the indexed set
CurrLRU       input   1      LRU bit of the set (1 = way2 most recently written)
BusReady      input   1      bus accepted/returned one word this cycle
W1WE, W2WE    output  1      way write enables
DirtyIn       output  1      dirty value written with the line
vin           output  1      valid value written with the line
UseBusWD      output  1      1 = cache write data comes from the bus read data
FullMask      output  1      1 = force byte mask 4'b1111 on the write
WordOffset    output  2      word index driven onto the block-offset bits of ANew
UseCount      output  1      1 = WordOffset overrides the CPU address offset
WaySel        output  1      way selected for read data (0 = way1, 1 = way2)
UseVictimTag  output  1      1 = bus address uses the victim tag, not PhysTag
BusRE, BusWE  output  1      bus read / bus write strobe
Stall         output  1      freeze the pipeline

Behaviour:
- Hit1 = W1V & (W1Tag==PhysTag); Hit2 likewise; Hit = Hit1|Hit2. If both hit (illegal), way1 wins.
- States: READY, WRITEBACK, FILL. Registers: state, count[$clog2(bsize)-1:0], victim (1 bit), all updated on posedge clk.
- Reset (synchronous, takes effect at the clock edge, also mid-operation): state=READY, count=0, victim=0, so every output is 0 including Stall. An interrupted fill leaves the partially written line valid; this is accepted and software reflushes after reset.
- READY, no request: all outputs 0.
- READY, load hit: Stall=0, WaySel=Hit2, no write. Zero added latency.
- READY, store hit: enable of the hit way=1, DirtyIn=1, vin=1, UseBusWD=0, FullMask=0, Stall=0. Single cycle.
- READY, miss ((MemRE|MemWE) & ~Hit): Stall=1 combinationally.
  - Victim selection: way1 if !W1V; else way2 if !W2V; else way1 if CurrLRU=1, otherwise way2. Latch it into victim.
  - Next state: WRITEBACK if the victim's dirty bit is set, else FILL. count=0.
- WRITEBACK:
  - Outputs: Stall=1, BusWE=1, UseVictimTag=1, UseCount=1, WordOffset=count, WaySel=victim.
  - BusReady=1 increments count. At count==bsize-1 with BusReady, count wraps to 0 and the next state is FILL.
  - BusReady=0 holds count and all outputs.
- FILL:
  - Outputs: Stall=1, BusRE=1, UseCount=1, WordOffset=count.
  - On BusReady: victim-way WE=1, UseBusWD=1, FullMask=1, DirtyIn=0, vin=1, count increments.
  - At the last word, the next state is READY. The request is re-looked-up there and now hits; a store then sets dirty.
- Request deasserted during WRITEBACK/FILL: the sequence still completes, so the block is never left half-written.
- WE, DirtyIn, vin and UseBusWD are only asserted together with the corresponding condition above; they are 0 in every other state/cycle.
- Latency with BusReady always 1:
  - Clean miss: 1 cycle (READY) + bsize (FILL) + 1 (hit).
  - Dirty miss: adds bsize cycles.

Test Plan:
- Reset, then a load with W1V=1 and W1Tag==PhysTag=14'h0A5 -> Stall=0, WaySel=0, W1WE=W2WE=0.
- Store hitting way2 -> W2WE=1, DirtyIn=1, vin=1, Stall=0 for exactly one cycle.
- Load miss, W1V=0 -> FILL with victim way1; over 4 BusReady cycles WordOffset 0,1,2,3 with W1WE=1, FullMask=1, DirtyIn=0; READY on cycle 6, where Stall=0.
- Store miss, both valid, CurrLRU=0, W2D=1 -> 4 WRITEBACK cycles (BusWE=1, UseVictimTag=1, WaySel=1), then 4 FILL writes to way2, then the hit store sets DirtyIn=1. Stall is high for 9 cycles.
- FILL with BusReady toggling 1,0,0,1,1,0,1 -> count advances only on high cycles; W2WE asserts only when BusReady=1.
- Reset asserted in WRITEBACK with count=2 -> the next cycle has state READY, count=0, and all outputs 0.
